uart_rx: RTL and testbench

UART receiver that sits directly downstream of the UART transmitter. It consumes the serial line produced by the transmitter: 8N1 frames, LSB first, idle-high line, same CLK_FREQ/BAUD_RATE divider scheme. It synchronises the asynchronous rx line, validates the start bit at mid-bit, samples each data bit at its centre and checks the stop bit. It delivers one parallel byte per frame with a single-cycle valid strobe, or flags a framing error.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and status strobes out
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  rx_active;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, rx_active
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, rx_active
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing check
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CLK_DIVIDE  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIVIDE = CLK_DIVIDE / 2;
  localparam int CNT_W       = $clog2(CLK_DIVIDE) + 1;
  localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIVIDE - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIVIDE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] ERR_WAIT = 3'd5;

  logic                  s1_q, rx_sync_q;
  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      clk_div_q, clk_div_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_active_q, rx_active_d;

  always_comb begin
    state_d   = state_q;
    clk_div_d = clk_div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;

    case (state_q)
      IDLE: begin
        clk_div_d = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        // A start bit that is gone again by its centre is treated as a glitch.
        if (clk_div_q == HALF_LAST) begin
          clk_div_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          clk_div_d = clk_div_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_div_q == DIV_LAST) begin
          clk_div_d          = '0;
          shift_d[bit_idx_q] = rx_sync_q;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          clk_div_d = clk_div_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_div_q == DIV_LAST) begin
          clk_div_d = '0;
          if (rx_sync_q) begin
            rx_data_d = shift_q;
            state_d   = DONE;
          end else begin
            state_d   = ERR_WAIT;
          end
        end else begin
          clk_div_d = clk_div_q + CNT_W'(1);
        end
      end
      DONE:     state_d = IDLE;
      // Hold here through a break so a low line cannot retrigger frames.
      ERR_WAIT: if (rx_sync_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    rx_valid_d  = (state_d == DONE);
    frame_err_d = (state_d == ERR_WAIT) && (state_q != ERR_WAIT);
    rx_active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      clk_div_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      s1_q        <= bus.rx;
      rx_sync_q   <= s1_q;
      state_q     <= state_d;
      clk_div_q   <= clk_div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_active_q <= rx_active_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_active = rx_active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(
    .CLK_FREQ  (160),
    .BAUD_RATE (10),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  int         valid_cnt   = 0;
  int         err_cnt     = 0;
  int         pulse_viol  = 0;
  int         active_viol = 0;
  logic       prev_v      = 1'b0;
  logic       prev_e      = 1'b0;
  logic [7:0] vq[$];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cnt++;
      vq.push_back(bus.rx_data);
      if (bus.rx_active) active_viol++;
    end
    if (bus.frame_err) err_cnt++;
    if (bus.rx_valid && bus.frame_err) pulse_viol++;
    if ((bus.rx_valid && prev_v) || (bus.frame_err && prev_e)) pulse_viol++;
    prev_v = bus.rx_valid;
    prev_e = bus.frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int per,
                            input int hold_low);
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    drive_bit(stop, per);
    if (!stop && hold_low > 0) drive_bit(1'b0, hold_low);
    bus.rx = 1'b1;
  endtask

  task automatic wait_inactive(input string name);
    int k;
    for (k = 0; k < 300 && bus.rx_active; k++) begin
      @(posedge clk);
      #1;
    end
    check(name, int'(bus.rx_active), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         period;
    int         hold_low;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_rx_data;
  } vec_t;

  vec_t       vecs[$];
  int         vb, eb;
  logic [7:0] model_data;
  logic [7:0] rd;

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 16, 0,  1, 0, 8'hA5});
    vecs.push_back('{8'h00, 1'b1, 16, 0,  1, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 16, 0,  1, 0, 8'hFF});
    vecs.push_back('{8'h3C, 1'b0, 16, 40, 0, 1, 8'hFF});
    vecs.push_back('{8'hC3, 1'b1, 15, 0,  1, 0, 8'hC3});
    vecs.push_back('{8'h3C, 1'b1, 16, 0,  1, 0, 8'h3C});
    vecs.push_back('{8'hC3, 1'b1, 17, 0,  1, 0, 8'hC3});

    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_data",   int'(bus.rx_data),   0);
    check("reset rx_valid",  int'(bus.rx_valid),  0);
    check("reset frame_err", int'(bus.frame_err), 0);
    check("reset rx_active", int'(bus.rx_active), 0);
    rst = 1'b1;
    drive_bit(1'b1, 10);

    foreach (vecs[i]) begin
      vb = valid_cnt;
      eb = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].period, vecs[i].hold_low);
      drive_bit(1'b1, 30);
      wait_inactive($sformatf("vec%0d idle", i));
      check($sformatf("vec%0d valid count", i), valid_cnt - vb, vecs[i].exp_valid);
      check($sformatf("vec%0d err count", i), err_cnt - eb, vecs[i].exp_err);
      check($sformatf("vec%0d rx_data", i), int'(bus.rx_data), int'(vecs[i].exp_rx_data));
    end

    // back-to-back frames with no idle gap between stop and next start
    vb = valid_cnt;
    send_frame(8'h00, 1'b1, 16, 0);
    send_frame(8'hFF, 1'b1, 16, 0);
    drive_bit(1'b1, 30);
    check("b2b valid count", valid_cnt - vb, 2);
    if (vq.size() >= 2) begin
      check("b2b first byte",  int'(vq[vq.size()-2]), 8'h00);
      check("b2b second byte", int'(vq[vq.size()-1]), 8'hFF);
    end else begin
      check("b2b strobes seen", vq.size(), 2);
    end

    // short low glitch must be ignored
    rd = bus.rx_data;
    vb = valid_cnt;
    eb = err_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("glitch valid", valid_cnt - vb, 0);
    check("glitch err", err_cnt - eb, 0);
    check("glitch rx_data", int'(bus.rx_data), int'(rd));
    check("glitch rx_active", int'(bus.rx_active), 0);

    // reset during data bit 3 of 0x5A, then the line goes idle
    vb = valid_cnt;
    eb = err_cnt;
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset rx_data",   int'(bus.rx_data),   0);
    check("midreset rx_valid",  int'(bus.rx_valid),  0);
    check("midreset frame_err", int'(bus.frame_err), 0);
    check("midreset rx_active", int'(bus.rx_active), 0);
    rst = 1'b1;
    drive_bit(1'b1, 200);
    check("midreset no valid", valid_cnt - vb, 0);
    check("midreset no err", err_cnt - eb, 0);
    send_frame(8'h81, 1'b1, 16, 0);
    drive_bit(1'b1, 30);
    check("post-reset valid", valid_cnt - vb, 1);
    check("post-reset rx_data", int'(bus.rx_data), 8'h81);

    // random frames against a frame-level model
    model_data = bus.rx_data;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       s;
      int         gap;
      d   = 8'($urandom);
      s   = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(4, 20);
      vb  = valid_cnt;
      eb  = err_cnt;
      send_frame(d, s, 16, 0);
      drive_bit(1'b1, gap);
      if (s) model_data = d;
      check($sformatf("rand%0d valid", n), valid_cnt - vb, s ? 1 : 0);
      check($sformatf("rand%0d err", n), err_cnt - eb, s ? 0 : 1);
      check($sformatf("rand%0d rx_data", n), int'(bus.rx_data), int'(model_data));
    end
    drive_bit(1'b1, 20);

    check("pulse rules", pulse_viol, 0);
    check("active at valid", active_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
